// File: rtl/pwm_audio_tx.sv
// PWM audio transmitter: 12-bit samples arrive on a valid/ready stream into a small FIFO.
// One sample is consumed per PWM period and drives the duty of a registered PWM bit.
module pwm_audio_tx #(
  parameter int PWM_W   = 12,
  parameter int FIFO_AW = 4
) (
  input  logic               clk100,
  input  logic               RESET_N,
  input  logic               en,
  input  logic [PWM_W-1:0]   s_data,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               clr_underrun,
  output logic               AUD_PWM,
  output logic               AUD_SD,
  output logic               underrun,
  output logic [FIFO_AW:0]   level
);

  localparam int                DEPTH   = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]  DEPTH_L = (FIFO_AW + 1)'(DEPTH);

  logic [PWM_W-1:0]   r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [FIFO_AW:0]   r_level;
  logic [PWM_W-1:0]   r_cnt, r_duty;
  logic               r_pwm, r_sd, r_underrun;

  logic               w_full, w_empty, w_push, w_pop, w_bnd;
  logic [PWM_W-1:0]   w_cnt_next, w_duty_next;
  logic [FIFO_AW:0]   w_level_next;

  always_comb begin
    w_full       = (r_level == DEPTH_L);
    w_empty      = (r_level == '0);
    w_push       = s_valid && !w_full;
    w_bnd        = en && (r_cnt == '1);
    w_pop        = w_bnd && !w_empty;
    w_cnt_next   = en ? r_cnt + 1'b1 : '1;
    // The freshly popped sample must already govern the cnt==0 slot of the new period.
    w_duty_next  = w_pop ? r_mem[r_rptr] : r_duty;
    w_level_next = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + 1'b1;
      2'b01:   w_level_next = r_level - 1'b1;
      default: w_level_next = r_level;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (w_push) r_mem[r_wptr] <= s_data;
  end

  always_ff @(posedge clk100 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_cnt      <= '1;
      r_duty     <= '0;
      r_pwm      <= 1'b0;
      r_sd       <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_level <= w_level_next;
      r_cnt   <= w_cnt_next;
      r_duty  <= w_duty_next;
      r_pwm   <= en && (w_cnt_next < w_duty_next);
      r_sd    <= en;
      if (w_bnd && w_empty)   r_underrun <= 1'b1;
      else if (clr_underrun)  r_underrun <= 1'b0;
    end
  end

  assign s_ready  = !w_full;
  assign AUD_PWM  = r_pwm;
  assign AUD_SD   = r_sd;
  assign underrun = r_underrun;
  assign level    = r_level;

endmodule

// File: tb/tb_pwm_audio_tx.sv
// Bench for pwm_audio_tx: directed scenarios plus a random phase, all checked every cycle
// against a sample-queue / period-phase model of the player.
module tb_pwm_audio_tx;

  logic        clk100 = 1'b0;
  logic        RESET_N;
  logic        en;
  logic [11:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        clr_underrun;
  logic        AUD_PWM;
  logic        AUD_SD;
  logic        underrun;
  logic [4:0]  level;

  pwm_audio_tx #(.PWM_W(12), .FIFO_AW(4)) dut (
    .clk100(clk100), .RESET_N(RESET_N), .en(en), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .clr_underrun(clr_underrun), .AUD_PWM(AUD_PWM), .AUD_SD(AUD_SD),
    .underrun(underrun), .level(level)
  );

  always #5 clk100 = ~clk100;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: queue of pending samples, position inside the period, current duty.
  int mq[$];
  int m_phase = 4095;
  int m_duty  = 0;
  bit m_pwm = 0, m_sd = 0, m_ur = 0, m_acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_phase = 4095; m_duty = 0; m_pwm = 0; m_sd = 0; m_ur = 0; m_acc = 0;
  endtask

  task automatic model_edge();
    bit full, empty, bnd;
    full  = (mq.size() == 16);
    empty = (mq.size() == 0);
    bnd   = en && (m_phase == 4095);
    if (bnd && empty)      m_ur = 1;
    else if (clr_underrun) m_ur = 0;
    if (bnd && !empty) m_duty = mq.pop_front();
    m_acc = s_valid && !full;
    if (m_acc) mq.push_back(int'(s_data));
    m_phase = en ? (m_phase + 1) % 4096 : 4095;
    m_pwm   = en && (m_phase < m_duty);
    m_sd    = en;
  endtask

  task automatic step();
    @(posedge clk100);
    model_edge();
    #1;
    chk("pwm",      AUD_PWM,  m_pwm);
    chk("sd",       AUD_SD,   m_sd);
    chk("underrun", underrun, m_ur);
    chk("level",    level,    mq.size());
    chk("s_ready",  s_ready,  mq.size() < 16);
  endtask

  // Current step is phase 0; accumulate high cycles over the whole period.
  task automatic count_period(output int hi);
    hi = int'(AUD_PWM);
    repeat (4095) begin step(); hi += int'(AUD_PWM); end
  endtask

  task automatic wait_phase(input int target);
    int n = 0;
    do begin step(); n++; end while (m_phase != target && n < 9000);
    n_cmp++;
    assert (m_phase == target) else begin
      n_err++;
      $error("FAIL wait_phase observed=%0d expected=%0d", m_phase, target);
    end
  endtask

  initial begin
    int hi, idx, n;
    logic [11:0] samp [20];
    RESET_N = 1'b0; en = 1'b0; s_data = '0; s_valid = 1'b0; clr_underrun = 1'b0;
    #12;
    model_reset();
    chk("rst_pwm", AUD_PWM, 0);
    chk("rst_sd", AUD_SD, 0);
    chk("rst_ur", underrun, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", s_ready, 1);
    RESET_N = 1'b1;

    // 1: half-duty sample
    s_valid = 1; s_data = 12'h800; step();
    s_valid = 0; en = 1; step();
    chk("t1_level", level, 0);
    count_period(hi);
    chk("t1_high", hi, 2048);

    // 2: silence floor then full duty
    s_valid = 1; s_data = 12'h000; step();
    s_data = 12'hFFF; step();
    s_valid = 0;
    wait_phase(0);
    count_period(hi);
    chk("t2_zero", hi, 0);
    step();
    count_period(hi);
    chk("t2_full", hi, 4095);

    // 3: burst of 20 while disabled, then play in order
    en = 0; clr_underrun = 1; step(); clr_underrun = 0;
    foreach (samp[k]) samp[k] = 12'($urandom);
    idx = 0;
    for (int k = 0; k < 24; k++) begin
      s_data = samp[idx]; s_valid = (idx < 20); step();
      if (m_acc) idx++;
    end
    chk("t3_ready", s_ready, 0);
    chk("t3_level", level, 16);
    chk("t3_accepted_16", idx, 16);
    en = 1;
    repeat (5 * 4096) begin
      s_data = samp[idx % 20]; s_valid = (idx < 20); step();
      if (m_acc) idx++;
    end
    s_valid = 0;
    chk("t3_accepted_all", idx, 20);

    // 6: asynchronous reset while full-ish and PWM high
    n = 0;
    while (AUD_PWM !== 1'b1 && n < 9000) begin step(); n++; end
    chk("t6_pwm_high_seen", AUD_PWM, 1);
    #2 RESET_N = 1'b0; en = 0;
    #1;
    model_reset();
    chk("t6_pwm", AUD_PWM, 0);
    chk("t6_sd", AUD_SD, 0);
    chk("t6_ur", underrun, 0);
    chk("t6_level", level, 0);
    chk("t6_ready", s_ready, 1);
    #1 RESET_N = 1'b1;

    // 4: underrun repeats last sample; set beats clear
    s_valid = 1; s_data = 12'h400; step();
    s_valid = 0; en = 1; step();
    chk("t4_level", level, 0);
    count_period(hi);
    chk("t4_high", hi, 1024);
    step();
    chk("t4_ur_set", underrun, 1);
    count_period(hi);
    chk("t4_repeat", hi, 1024);
    clr_underrun = 1; step();
    chk("t4_set_wins", underrun, 1);
    step(); clr_underrun = 0;
    chk("t4_clr", underrun, 0);

    // 5: drop en mid-period, resume with a fresh period
    s_valid = 1; s_data = 12'h123; step(); s_valid = 0;
    wait_phase(1000);
    en = 0; step();
    chk("t5_pwm_off", AUD_PWM, 0);
    chk("t5_sd_off", AUD_SD, 0);
    chk("t5_level_kept", level, 1);
    repeat (7) step();
    en = 1; step();
    chk("t5_loaded", level, 0);
    chk("t5_resume", AUD_PWM, 1);

    // random traffic
    repeat (6000) begin
      if ($urandom_range(0, 499) == 0) en = ~en;
      s_valid      = ($urandom_range(0, 3) == 0);
      s_data       = 12'($urandom);
      clr_underrun = ($urandom_range(0, 999) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
